// File: rtl/coreboard1588_bram_arbiter.sv
// coreboard1588_bram_arbiter
// Merges two 32-bit AXIS sample streams (S00 = ADS868x, S01 = ADS124x) onto
// one 16-bit BRAM write port. Each source owns half the BRAM. That half is
// split into two ping-pong banks. Each bank is stamped with the RTC time of
// its first sample. Bank completion raises a per-source pending flag, which
// drives a level IRQ, and is reported on the ts_* outputs.
module coreboard1588_bram_arbiter #(
    parameter int C_BRAM_ADDR_WIDTH = 12
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         ctrl_enable,
    input  logic [31:0]                  s00_axis_tdata,
    input  logic                         s00_axis_tvalid,
    output logic                         s00_axis_tready,
    input  logic [31:0]                  s01_axis_tdata,
    input  logic                         s01_axis_tvalid,
    output logic                         s01_axis_tready,
    input  logic [31:0]                  rtc_second,
    input  logic [31:0]                  rtc_nanosecond,
    output logic                         bram_clk,
    output logic                         bram_rst,
    output logic [C_BRAM_ADDR_WIDTH-1:0] bram_addr,
    output logic                         bram_en,
    output logic [1:0]                   bram_we,
    output logic [15:0]                  bram_din,
    input  logic [1:0]                   irq_ack,
    output logic                         irq,
    output logic [1:0]                   stat_overrun,
    output logic                         ts_valid,
    output logic                         ts_src,
    output logic                         ts_bank,
    output logic [31:0]                  ts_second,
    output logic [31:0]                  ts_nanosecond
);

    // Per-source pointer covers the bank bit plus the halfword offset.
    localparam int PW = C_BRAM_ADDR_WIDTH - 1;
    localparam int OW = C_BRAM_ADDR_WIDTH - 2;
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_STEP = {{(PW-2){1'b0}}, 2'b10};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_LO = 2'd1,
        ST_WR_HI = 2'd2
    } state_t;

    state_t                         state_q;
    logic [31:0]                    data_q;
    logic                           src_q;
    logic                           last_grant_q;
    logic [PW-1:0]                  ptr_q [2];
    logic [31:0]                    stage_sec_q [2];
    logic [31:0]                    stage_ns_q [2];
    logic [1:0]                     pending_q;
    logic [1:0]                     overrun_q;
    logic                           irq_q;
    logic                           ts_valid_q;
    logic                           ts_src_q;
    logic                           ts_bank_q;
    logic [31:0]                    ts_second_q;
    logic [31:0]                    ts_nanosecond_q;
    logic [C_BRAM_ADDR_WIDTH-1:0]   bram_addr_q;
    logic                           bram_en_q;
    logic [1:0]                     bram_we_q;
    logic [15:0]                    bram_din_q;

    logic                           grant_vld_s;
    logic                           grant_src_s;
    logic                           hs_s;
    logic [31:0]                    hs_data_s;
    logic [PW-1:0]                  hs_ptr_s;
    logic                           ts_capture_s;
    logic [PW-1:0]                  cur_ptr_s;
    logic [PW-1:0]                  ptr_inc_s;
    logic                           wrap_s;
    logic [1:0]                     compl_mask_s;
    logic [1:0]                     pending_d;
    logic [1:0]                     overrun_d;

    // Round-robin source selection: on contention the source not served last wins.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_src_s = 1'b0;
        if (s00_axis_tvalid && s01_axis_tvalid) begin
            grant_vld_s = 1'b1;
            grant_src_s = ~last_grant_q;
        end else if (s00_axis_tvalid) begin
            grant_vld_s = 1'b1;
            grant_src_s = 1'b0;
        end else if (s01_axis_tvalid) begin
            grant_vld_s = 1'b1;
            grant_src_s = 1'b1;
        end else begin
            grant_vld_s = 1'b0;
            grant_src_s = 1'b0;
        end
    end

    assign hs_s            = (state_q == ST_IDLE) & ctrl_enable & grant_vld_s;
    assign s00_axis_tready = hs_s & ~grant_src_s;
    assign s01_axis_tready = hs_s & grant_src_s;
    assign hs_data_s       = grant_src_s ? s01_axis_tdata : s00_axis_tdata;
    assign hs_ptr_s        = ptr_q[grant_src_s];
    assign ts_capture_s    = hs_s && (hs_ptr_s[OW-1:0] == {OW{1'b0}});
    assign cur_ptr_s       = ptr_q[src_q];
    assign ptr_inc_s       = cur_ptr_s + PTR_STEP;

    // Bank completion and pending/overrun next state; a same-cycle ack and completion keeps pending without overrun.
    always_comb begin
        wrap_s       = 1'b0;
        compl_mask_s = 2'b00;
        if ((state_q == ST_WR_HI) && (ptr_inc_s[OW-1:0] == {OW{1'b0}})) begin
            wrap_s       = 1'b1;
            compl_mask_s = src_q ? 2'b10 : 2'b01;
        end else begin
            wrap_s       = 1'b0;
            compl_mask_s = 2'b00;
        end
        pending_d = (pending_q & ~irq_ack) | compl_mask_s;
        overrun_d = overrun_q | (compl_mask_s & pending_q & ~irq_ack);
    end

    // Write FSM: latches the granted sample, then drives the low and high halfword writes from registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            data_q       <= 32'h0000_0000;
            src_q        <= 1'b0;
            last_grant_q <= 1'b1;
            bram_en_q    <= 1'b0;
            bram_we_q    <= 2'b00;
            bram_addr_q  <= {C_BRAM_ADDR_WIDTH{1'b0}};
            bram_din_q   <= 16'h0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hs_s) begin
                        data_q       <= hs_data_s;
                        src_q        <= grant_src_s;
                        last_grant_q <= grant_src_s;
                        bram_en_q    <= 1'b1;
                        bram_we_q    <= 2'b11;
                        bram_addr_q  <= {grant_src_s, hs_ptr_s};
                        bram_din_q   <= hs_data_s[15:0];
                        state_q      <= ST_WR_LO;
                    end else begin
                        bram_en_q    <= 1'b0;
                        bram_we_q    <= 2'b00;
                        state_q      <= ST_IDLE;
                    end
                end
                ST_WR_LO: begin
                    bram_en_q   <= 1'b1;
                    bram_we_q   <= 2'b11;
                    bram_addr_q <= {src_q, cur_ptr_s + PTR_ONE};
                    bram_din_q  <= data_q[31:16];
                    state_q     <= ST_WR_HI;
                end
                ST_WR_HI: begin
                    bram_en_q <= 1'b0;
                    bram_we_q <= 2'b00;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    bram_en_q <= 1'b0;
                    bram_we_q <= 2'b00;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    // Pointers, first-sample timestamps, completion report and IRQ bookkeeping.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr_q[0]        <= {PW{1'b0}};
            ptr_q[1]        <= {PW{1'b0}};
            stage_sec_q[0]  <= 32'h0000_0000;
            stage_sec_q[1]  <= 32'h0000_0000;
            stage_ns_q[0]   <= 32'h0000_0000;
            stage_ns_q[1]   <= 32'h0000_0000;
            pending_q       <= 2'b00;
            overrun_q       <= 2'b00;
            irq_q           <= 1'b0;
            ts_valid_q      <= 1'b0;
            ts_src_q        <= 1'b0;
            ts_bank_q       <= 1'b0;
            ts_second_q     <= 32'h0000_0000;
            ts_nanosecond_q <= 32'h0000_0000;
        end else begin
            if (state_q == ST_WR_HI) begin
                ptr_q[src_q] <= ptr_inc_s;
            end else if ((state_q == ST_IDLE) && !ctrl_enable) begin
                ptr_q[0] <= {PW{1'b0}};
                ptr_q[1] <= {PW{1'b0}};
            end else begin
                ptr_q[0] <= ptr_q[0];
                ptr_q[1] <= ptr_q[1];
            end

            if (ts_capture_s) begin
                stage_sec_q[grant_src_s] <= rtc_second;
                stage_ns_q[grant_src_s]  <= rtc_nanosecond;
            end else begin
                stage_sec_q[0] <= stage_sec_q[0];
                stage_ns_q[0]  <= stage_ns_q[0];
            end

            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            irq_q      <= |pending_d;
            ts_valid_q <= wrap_s;

            if (wrap_s) begin
                ts_src_q        <= src_q;
                ts_bank_q       <= cur_ptr_s[PW-1];
                ts_second_q     <= stage_sec_q[src_q];
                ts_nanosecond_q <= stage_ns_q[src_q];
            end else begin
                ts_src_q        <= ts_src_q;
            end
        end
    end

    assign bram_clk      = aclk;
    assign bram_rst      = ~aresetn;
    assign bram_addr     = bram_addr_q;
    assign bram_en       = bram_en_q;
    assign bram_we       = bram_we_q;
    assign bram_din      = bram_din_q;
    assign irq           = irq_q;
    assign stat_overrun  = overrun_q;
    assign ts_valid      = ts_valid_q;
    assign ts_src        = ts_src_q;
    assign ts_bank       = ts_bank_q;
    assign ts_second     = ts_second_q;
    assign ts_nanosecond = ts_nanosecond_q;

endmodule

// File: tb/tb_coreboard1588_bram_arbiter.sv
// Directed bench for coreboard1588_bram_arbiter: single write, round-robin
// contention, bank completion/IRQ, overrun, ack collision, disable and reset.
module tb_coreboard1588_bram_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        ctrl_enable;
    logic [31:0] s00_axis_tdata, s01_axis_tdata;
    logic        s00_axis_tvalid, s01_axis_tvalid;
    logic        s00_axis_tready, s01_axis_tready;
    logic [31:0] rtc_second, rtc_nanosecond;
    logic        bram_clk, bram_rst, bram_en;
    logic [11:0] bram_addr;
    logic [1:0]  bram_we;
    logic [15:0] bram_din;
    logic [1:0]  irq_ack;
    logic        irq;
    logic [1:0]  stat_overrun;
    logic        ts_valid, ts_src, ts_bank;
    logic [31:0] ts_second, ts_nanosecond;

    coreboard1588_bram_arbiter #(.C_BRAM_ADDR_WIDTH(12)) dut (
        .aclk(aclk), .aresetn(aresetn), .ctrl_enable(ctrl_enable),
        .s00_axis_tdata(s00_axis_tdata), .s00_axis_tvalid(s00_axis_tvalid),
        .s00_axis_tready(s00_axis_tready),
        .s01_axis_tdata(s01_axis_tdata), .s01_axis_tvalid(s01_axis_tvalid),
        .s01_axis_tready(s01_axis_tready),
        .rtc_second(rtc_second), .rtc_nanosecond(rtc_nanosecond),
        .bram_clk(bram_clk), .bram_rst(bram_rst), .bram_addr(bram_addr),
        .bram_en(bram_en), .bram_we(bram_we), .bram_din(bram_din),
        .irq_ack(irq_ack), .irq(irq), .stat_overrun(stat_overrun),
        .ts_valid(ts_valid), .ts_src(ts_src), .ts_bank(ts_bank),
        .ts_second(ts_second), .ts_nanosecond(ts_nanosecond)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [11:0] addr;
        logic [15:0] din;
        logic [1:0]  we;
    } wr_t;

    wr_t wlog[$];
    int  ts_pulses = 0;
    int  hs0 = 0;
    int  checks = 0;
    int  errors = 0;

    // Record every enabled BRAM cycle, ts_valid pulses and S00 handshakes on the falling edge.
    always @(negedge aclk) begin
        if (bram_en) wlog.push_back({bram_addr, bram_din, bram_we});
        if (ts_valid) ts_pulses++;
        if (s00_axis_tvalid && s00_axis_tready) hs0++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        wait_cycles(1);
    endtask

    // Offer one sample on a source, wait (bounded) for its handshake; returns #1 after the handshake edge.
    task automatic send_one(input logic src, input logic [31:0] data,
                            input logic [31:0] sec, input logic [31:0] ns);
        bit got;
        got = 1'b0;
        rtc_second = sec;
        rtc_nanosecond = ns;
        if (src) begin
            s01_axis_tdata = data;
            s01_axis_tvalid = 1'b1;
        end else begin
            s00_axis_tdata = data;
            s00_axis_tvalid = 1'b1;
        end
        for (int n = 0; n < 20; n++) begin
            @(negedge aclk);
            if ((src && s01_axis_tready) || (!src && s00_axis_tready)) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge aclk);
        #1;
        s00_axis_tvalid = 1'b0;
        s01_axis_tvalid = 1'b0;
        if (!got) check_eq("handshake", 32'(got), 32'd1);
    endtask

    initial begin
        wr_t  e;
        logic g;
        int   n0, n1, src, n;
        aresetn = 1'b0;
        ctrl_enable = 1'b1;
        s00_axis_tdata = 32'd0; s01_axis_tdata = 32'd0;
        s00_axis_tvalid = 1'b0; s01_axis_tvalid = 1'b0;
        rtc_second = 32'd0; rtc_nanosecond = 32'd0;
        irq_ack = 2'b00;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_eq("rst_en", 32'(bram_en), 32'd0);
        check_eq("rst_we", 32'(bram_we), 32'd0);
        check_eq("rst_addr", 32'(bram_addr), 32'd0);
        check_eq("rst_din", 32'(bram_din), 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_ovr", 32'(stat_overrun), 32'd0);
        check_eq("rst_tsv", 32'(ts_valid), 32'd0);
        check_eq("rst_tssec", ts_second, 32'd0);
        check_eq("rst_bram_rst", 32'(bram_rst), 32'd1);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        wait_cycles(2);
        check_eq("run_bram_rst", 32'(bram_rst), 32'd0);

        // Single sample
        wlog.delete(); hs0 = 0;
        send_one(1'b0, 32'hDEADBEEF, 32'd0, 32'd0);
        wait_cycles(4);
        check_eq("single_hs", 32'(hs0), 32'd1);
        check_eq("single_nwr", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            e = wlog[0];
            check_eq("single_a0", 32'(e.addr), 32'h000);
            check_eq("single_d0", 32'(e.din), 32'hBEEF);
            check_eq("single_w0", 32'(e.we), 32'd3);
            e = wlog[1];
            check_eq("single_a1", 32'(e.addr), 32'h001);
            check_eq("single_d1", 32'(e.din), 32'hDEAD);
            check_eq("single_w1", 32'(e.we), 32'd3);
        end

        // Contention: round-robin starting with S00 after reset
        do_reset();
        wlog.delete();
        n0 = 1; n1 = 1;
        s00_axis_tdata = 32'h0000_0001; s01_axis_tdata = 32'h1000_0001;
        s00_axis_tvalid = 1'b1; s01_axis_tvalid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            g = 1'b0;
            for (int t = 0; t < 10; t++) begin
                @(negedge aclk);
                if (s00_axis_tready || s01_axis_tready) break;
            end
            g = s01_axis_tready;
            check_eq("cont_grant", 32'(g), 32'(k % 2));
            check_eq("cont_any", 32'(s00_axis_tready | s01_axis_tready), 32'd1);
            @(posedge aclk);
            #1;
            if (g) begin n1++; s01_axis_tdata = 32'h1000_0000 | n1; end
            else begin n0++; s00_axis_tdata = 32'(n0); end
        end
        s00_axis_tvalid = 1'b0; s01_axis_tvalid = 1'b0;
        wait_cycles(4);
        check_eq("cont_nwr", 32'(wlog.size()), 32'd12);
        for (int i = 0; i < 6 && (2 * i + 1) < wlog.size(); i++) begin
            src = i % 2;
            n = i / 2 + 1;
            e = wlog[2 * i];
            check_eq("cont_alo", 32'(e.addr), 32'((src << 11) | (2 * (n - 1))));
            check_eq("cont_dlo", 32'(e.din), 32'(n));
            e = wlog[2 * i + 1];
            check_eq("cont_ahi", 32'(e.addr), 32'((src << 11) | (2 * (n - 1) + 1)));
            check_eq("cont_dhi", 32'(e.din), (src == 1) ? 32'h1000 : 32'h0000);
        end

        // Bank completion on S01 (disable clears pointers first)
        ctrl_enable = 1'b0;
        wait_cycles(2);
        ctrl_enable = 1'b1;
        wlog.delete(); ts_pulses = 0;
        for (int i = 0; i < 512; i++)
            send_one(1'b1, 32'(i), (i == 0) ? 32'd5 : 32'd7, (i == 0) ? 32'd100 : 32'd999);
        wait_cycles(4);
        check_eq("bank_pulses", 32'(ts_pulses), 32'd1);
        check_eq("bank_src", 32'(ts_src), 32'd1);
        check_eq("bank_bank", 32'(ts_bank), 32'd0);
        check_eq("bank_sec", ts_second, 32'd5);
        check_eq("bank_ns", ts_nanosecond, 32'd100);
        check_eq("bank_irq", 32'(irq), 32'd1);
        check_eq("bank_ovr", 32'(stat_overrun), 32'd0);
        check_eq("bank_nwr", 32'(wlog.size()), 32'd1024);
        if (wlog.size() == 1024) begin
            e = wlog[0];
            check_eq("bank_first", 32'(e.addr), 32'h800);
            e = wlog[1023];
            check_eq("bank_last", 32'(e.addr), 32'hBFF);
        end
        irq_ack = 2'b10;
        wait_cycles(1);
        irq_ack = 2'b00;
        wait_cycles(1);
        check_eq("ack_irq", 32'(irq), 32'd0);

        // Overrun on S00: two completions without ack
        ts_pulses = 0;
        for (int i = 0; i < 512; i++)
            send_one(1'b0, 32'hA000_0000 | i, (i == 0) ? 32'd9 : 32'd1, (i == 0) ? 32'd333 : 32'd1);
        wait_cycles(4);
        check_eq("ovr1_pulses", 32'(ts_pulses), 32'd1);
        check_eq("ovr1_bank", 32'(ts_bank), 32'd0);
        check_eq("ovr1_src", 32'(ts_src), 32'd0);
        check_eq("ovr1_sec", ts_second, 32'd9);
        check_eq("ovr1_ovr", 32'(stat_overrun), 32'd0);
        for (int i = 0; i < 512; i++)
            send_one(1'b0, 32'hB000_0000 | i, (i == 0) ? 32'd11 : 32'd2, (i == 0) ? 32'd222 : 32'd2);
        wait_cycles(4);
        check_eq("ovr2_pulses", 32'(ts_pulses), 32'd2);
        check_eq("ovr2_bank", 32'(ts_bank), 32'd1);
        check_eq("ovr2_sec", ts_second, 32'd11);
        check_eq("ovr2_ns", ts_nanosecond, 32'd222);
        check_eq("ovr2_ovr", 32'(stat_overrun), 32'd1);
        check_eq("ovr2_irq", 32'(irq), 32'd1);
        wlog.delete();
        send_one(1'b0, 32'h1234_5678, 32'd0, 32'd0);
        wait_cycles(4);
        check_eq("wrap_nwr", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            e = wlog[0];
            check_eq("wrap_addr", 32'(e.addr), 32'h000);
            check_eq("wrap_din", 32'(e.din), 32'h5678);
        end

        // Ack landing in the same cycle as S00's second completion
        do_reset();
        for (int i = 0; i < 512; i++) send_one(1'b0, 32'(i), 32'd3, 32'd3);
        wait_cycles(4);
        check_eq("coll_irq1", 32'(irq), 32'd1);
        for (int i = 0; i < 511; i++)
            send_one(1'b0, 32'(i), (i == 0) ? 32'd13 : 32'd4, (i == 0) ? 32'd444 : 32'd4);
        send_one(1'b0, 32'hFFFF_0000, 32'd4, 32'd4);
        @(posedge aclk);
        #1;
        irq_ack = 2'b01;
        @(posedge aclk);
        #1;
        irq_ack = 2'b00;
        wait_cycles(3);
        check_eq("coll_irq", 32'(irq), 32'd1);
        check_eq("coll_ovr", 32'(stat_overrun), 32'd0);
        check_eq("coll_bank", 32'(ts_bank), 32'd1);
        check_eq("coll_sec", ts_second, 32'd13);

        // ctrl_enable dropped during WR_LO
        wlog.delete(); hs0 = 0;
        send_one(1'b0, 32'h1111_2222, 32'd0, 32'd0);
        send_one(1'b0, 32'h3333_4444, 32'd0, 32'd0);
        ctrl_enable = 1'b0;
        s00_axis_tdata = 32'hCAFE_0123;
        s00_axis_tvalid = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge aclk);
            check_eq("dis_tready", 32'(s00_axis_tready), 32'd0);
        end
        check_eq("dis_hs", 32'(hs0), 32'd2);
        check_eq("dis_nwr", 32'(wlog.size()), 32'd4);
        if (wlog.size() == 4) begin
            e = wlog[2];
            check_eq("dis_alo", 32'(e.addr), 32'h002);
            check_eq("dis_dlo", 32'(e.din), 32'h4444);
            e = wlog[3];
            check_eq("dis_ahi", 32'(e.addr), 32'h003);
            check_eq("dis_dhi", 32'(e.din), 32'h3333);
        end
        check_eq("dis_irq", 32'(irq), 32'd1);
        check_eq("dis_tsbank", 32'(ts_bank), 32'd1);
        check_eq("dis_tssec", ts_second, 32'd13);
        s00_axis_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        ctrl_enable = 1'b1;
        send_one(1'b0, 32'hCAFE_0123, 32'd0, 32'd0);
        wait_cycles(4);
        check_eq("reen_nwr", 32'(wlog.size()), 32'd6);
        if (wlog.size() == 6) begin
            e = wlog[4];
            check_eq("reen_addr", 32'(e.addr), 32'h000);
            check_eq("reen_din", 32'(e.din), 32'h0123);
        end

        // Asynchronous reset during WR_HI
        send_one(1'b0, 32'h5555_6666, 32'd0, 32'd0);
        @(posedge aclk);
        #2;
        check_eq("arst_pre_en", 32'(bram_en), 32'd1);
        aresetn = 1'b0;
        #1;
        check_eq("arst_en", 32'(bram_en), 32'd0);
        check_eq("arst_we", 32'(bram_we), 32'd0);
        check_eq("arst_addr", 32'(bram_addr), 32'd0);
        check_eq("arst_din", 32'(bram_din), 32'd0);
        check_eq("arst_irq", 32'(irq), 32'd0);
        check_eq("arst_ovr", 32'(stat_overrun), 32'd0);
        check_eq("arst_tssec", ts_second, 32'd0);
        check_eq("arst_tsbank", 32'(ts_bank), 32'd0);
        check_eq("arst_bram_rst", 32'(bram_rst), 32'd1);
        wait_cycles(2);
        aresetn = 1'b1;
        wait_cycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
